// File: rtl/e3_to_bcd_seq.sv
// Sequential Excess-3 to BCD decoder.
// Collects DIGITS Excess-3 digits (MSD first) over a valid/ready handshake,
// then presents the packed BCD word and per-digit invalid mask on a held
// output handshake.
module e3_to_bcd_seq #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_e3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_err,
    output logic [DIGITS-1:0]   out_err_mask
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS) + 1;

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [W-1:0]      work;
    logic [W-1:0]      work_shifted;
    logic [DIGITS-1:0] work_mask;
    logic [DIGITS-1:0] mask_shifted;
    logic [3:0]        dig;
    logic              dig_err;
    logic              accept;
    logic              last;

    // Decode one Excess-3 digit; invalid codes decode to zero and flag an error.
    always_comb begin
        dig_err = (in_e3 < 4'h3) || (in_e3 > 4'hC);
        dig     = dig_err ? 4'h0 : (in_e3 - 4'h3);
    end

    assign accept       = in_valid & in_ready;
    assign last         = (cnt == CW'(DIGITS - 1));
    assign work_shifted = (work << 4) | W'(dig);
    assign mask_shifted = (work_mask << 1) | DIGITS'(dig_err);
    assign out_err      = |out_err_mask;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; both handshakes depend only on state.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Working shift register, digit counter and output word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            work         <= '0;
            work_mask    <= '0;
            out_bcd      <= '0;
            out_err_mask <= '0;
        end else if (accept) begin
            if (last) begin
                out_bcd      <= work_shifted;
                out_err_mask <= mask_shifted;
                cnt          <= '0;
                work         <= '0;
                work_mask    <= '0;
            end else begin
                cnt       <= cnt + 1'b1;
                work      <= work_shifted;
                work_mask <= mask_shifted;
            end
        end
    end

endmodule
